// File: rtl/regfile_writeback_sequencer.sv
// Write-side front end of the AVR register file: buffers 8/16-bit write-back requests in a FIFO
// and issues them one byte per clock, flagging read addresses that hit a pending write.
module regfile_writeback_sequencer #(
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clock,
  input  logic                clr_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic                req_pair,
  input  logic [2*DATA_W-1:0] req_data,
  output logic [ADDR_W-1:0]   WA,
  output logic [DATA_W-1:0]   WD,
  output logic                RegWrite,
  input  logic [ADDR_W-1:0]   hz_addr,
  output logic                hz_match,
  output logic                busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {
    PH_LO,
    PH_HI
  } phase_t;

  logic [ADDR_W-1:0]   addr_mem [FIFO_DEPTH];
  logic                pair_mem [FIFO_DEPTH];
  logic [2*DATA_W-1:0] data_mem [FIFO_DEPTH];

  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [CNT_W-1:0]    count;
  phase_t              phase, phase_nx;

  logic                push, pop, empty;
  logic [ADDR_W-1:0]   head_addr;
  logic                head_pair;
  logic [2*DATA_W-1:0] head_data;
  logic [ADDR_W-1:0]   wa_nx;
  logic [DATA_W-1:0]   wd_nx;
  logic                rw_nx;

  assign empty     = (count == '0);
  assign req_ready = (count != CNT_W'(FIFO_DEPTH));
  assign push      = req_valid & req_ready;
  assign busy      = ~empty | RegWrite;

  assign head_addr = addr_mem[rd_ptr];
  assign head_pair = pair_mem[rd_ptr];
  assign head_data = data_mem[rd_ptr];

  // Storage needs no reset: occupancy is tracked by count alone.
  always_ff @(posedge clock) begin
    if (push) begin
      addr_mem[wr_ptr] <= req_addr;
      pair_mem[wr_ptr] <= req_pair;
      data_mem[wr_ptr] <= req_data;
    end
  end

  always_ff @(posedge clock or negedge clr_n) begin
    if (!clr_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      phase    <= PH_LO;
      WA       <= '0;
      WD       <= '0;
      RegWrite <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      phase    <= phase_nx;
      WA       <= wa_nx;
      WD       <= wd_nx;
      RegWrite <= rw_nx;
    end
  end

  // A pair stays at the FIFO head across both phases and is popped with its high byte.
  always_comb begin
    phase_nx = phase;
    pop      = 1'b0;
    wa_nx    = WA;
    wd_nx    = WD;
    rw_nx    = 1'b0;
    case (phase)
      PH_LO: begin
        if (!empty) begin
          rw_nx = 1'b1;
          wd_nx = head_data[DATA_W-1:0];
          if (head_pair) begin
            wa_nx    = {head_addr[ADDR_W-1:1], 1'b0};
            phase_nx = PH_HI;
          end else begin
            wa_nx = head_addr;
            pop   = 1'b1;
          end
        end
      end
      PH_HI: begin
        rw_nx    = 1'b1;
        wa_nx    = {head_addr[ADDR_W-1:1], 1'b1};
        wd_nx    = head_data[2*DATA_W-1:DATA_W];
        pop      = 1'b1;
        phase_nx = PH_LO;
      end
      default: phase_nx = PH_LO;
    endcase
  end

  always_comb begin : hz_scan
    logic [PTR_W-1:0] off;
    logic             covers;
    hz_match = RegWrite && (WA == hz_addr);
    for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
      off    = PTR_W'(i) - rd_ptr;
      covers = pair_mem[i] ? (addr_mem[i][ADDR_W-1:1] == hz_addr[ADDR_W-1:1])
                           : (addr_mem[i] == hz_addr);
      if (({1'b0, off} < count) && covers) hz_match = 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_writeback_sequencer.sv
// Scoreboard bench for regfile_writeback_sequencer: accepted requests expand into expected bytes,
// a negedge monitor checks issued bytes, busy, req_ready and hz_match against a queue model.
module tb_regfile_writeback_sequencer;
  localparam int AW    = 5;
  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic          clock, clr_n;
  logic          req_valid, req_ready, req_pair;
  logic [AW-1:0] req_addr, WA, hz_addr;
  logic [2*DW-1:0] req_data;
  logic [DW-1:0] WD;
  logic          RegWrite, hz_match, busy;

  regfile_writeback_sequencer #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clock(clock),
    .clr_n(clr_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_addr(req_addr),
    .req_pair(req_pair),
    .req_data(req_data),
    .WA(WA),
    .WD(WD),
    .RegWrite(RegWrite),
    .hz_addr(hz_addr),
    .hz_match(hz_match),
    .busy(busy)
  );

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wbyte_t;

  typedef struct {
    logic [AW-1:0] a;
    logic          pair;
    int            left;
  } wreq_t;

  wbyte_t        exp_q[$];
  wreq_t         pend_q[$];
  logic [DW-1:0] rf_ref [32];
  logic [DW-1:0] rf_dut [32];
  int            n_cmp, n_fail, run_len, max_run;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, want);
    end
  endtask

  task automatic model_push(input logic [AW-1:0] a, input logic p, input logic [2*DW-1:0] d);
    wbyte_t b;
    wreq_t  r;
    r.a = a; r.pair = p; r.left = p ? 2 : 1;
    pend_q.push_back(r);
    if (p) begin
      b.a = {a[AW-1:1], 1'b0}; b.d = d[DW-1:0];    exp_q.push_back(b);
      b.a = {a[AW-1:1], 1'b1}; b.d = d[2*DW-1:DW]; exp_q.push_back(b);
    end else begin
      b.a = a; b.d = d[DW-1:0]; exp_q.push_back(b);
    end
  endtask

  function automatic logic model_hz(input logic [AW-1:0] h, input logic inflight,
                                    input logic [AW-1:0] ia);
    logic m;
    m = inflight && (ia == h);
    foreach (pend_q[i])
      if (pend_q[i].pair ? (pend_q[i].a[AW-1:1] == h[AW-1:1]) : (pend_q[i].a == h)) m = 1'b1;
    return m;
  endfunction

  // Acceptance watcher: inputs and req_ready are stable mid low-phase.
  always @(negedge clock) begin
    #2;
    if (clr_n && req_valid && req_ready) model_push(req_addr, req_pair, req_data);
  end

  always @(negedge clock) begin : monitor
    wbyte_t        e;
    logic          issued;
    logic [AW-1:0] ia;
    issued = 1'b0;
    ia     = '0;
    if (clr_n) begin
      if (RegWrite) begin
        run_len++;
        if (run_len > max_run) max_run = run_len;
        rf_dut[WA] = WD;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_write: got WA=%0d WD=%0h, expected no write", WA, WD);
        end else begin
          e = exp_q.pop_front();
          chk("issue_wa", 32'(WA), 32'(e.a));
          chk("issue_wd", 32'(WD), 32'(e.d));
          rf_ref[e.a] = e.d;
          issued = 1'b1;
          ia     = e.a;
          if (pend_q.size() > 0) begin
            pend_q[0].left = pend_q[0].left - 1;
            if (pend_q[0].left == 0) pend_q.delete(0);
          end
        end
      end else begin
        run_len = 0;
      end
      chk("busy", 32'(busy), 32'((pend_q.size() != 0) || issued));
      chk("req_ready", 32'(req_ready), 32'(pend_q.size() != DEPTH));
      chk("hz_match", 32'(hz_match), 32'(model_hz(hz_addr, issued, ia)));
    end else begin
      run_len = 0;
    end
  end

  task automatic issue_req(input logic [AW-1:0] a, input logic p, input logic [2*DW-1:0] d);
    @(posedge clock); #1;
    req_valid = 1'b1; req_addr = a; req_pair = p; req_data = d;
    @(posedge clock); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    logic done;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clock);
      if (!busy) done = 1'b1;
    end
    #1;
    chk(name, 32'(done), 32'(1));
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int k, first_block;
    logic acc;
    n_cmp = 0; n_fail = 0; run_len = 0; max_run = 0;
    for (int r = 0; r < 32; r++) begin
      rf_ref[r] = '0;
      rf_dut[r] = '0;
    end
    clr_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_pair = 1'b0; req_data = '0; hz_addr = '0;

    // Reset
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_in_regwrite", 32'(RegWrite), 32'(0));
    chk("rst_in_ready", 32'(req_ready), 32'(1));
    @(posedge clock); #1 clr_n = 1'b1;
    @(negedge clock);
    chk("rst_regwrite", 32'(RegWrite), 32'(0));
    chk("rst_wa", 32'(WA), 32'(0));
    chk("rst_wd", 32'(WD), 32'(0));
    chk("rst_ready", 32'(req_ready), 32'(1));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_hz", 32'(hz_match), 32'(0));

    // Single byte
    issue_req(5'd5, 1'b0, 16'h00A5);
    @(negedge clock); chk("single_n0_rw", 32'(RegWrite), 32'(0));
    @(negedge clock);
    chk("single_rw", 32'(RegWrite), 32'(1));
    chk("single_wa", 32'(WA), 32'(5));
    chk("single_wd", 32'(WD), 32'(8'hA5));
    @(negedge clock); chk("single_n2_rw", 32'(RegWrite), 32'(0));
    chk("single_reg5", 32'(rf_dut[5]), 32'(8'hA5));

    // Pair
    issue_req(5'd25, 1'b1, 16'hBEEF);
    @(negedge clock); chk("pair_n0_rw", 32'(RegWrite), 32'(0));
    @(negedge clock);
    chk("pair_lo_rw", 32'(RegWrite), 32'(1));
    chk("pair_lo_wa", 32'(WA), 32'(24));
    chk("pair_lo_wd", 32'(WD), 32'(8'hEF));
    @(negedge clock);
    chk("pair_hi_rw", 32'(RegWrite), 32'(1));
    chk("pair_hi_wa", 32'(WA), 32'(25));
    chk("pair_hi_wd", 32'(WD), 32'(8'hBE));
    @(negedge clock); chk("pair_end_rw", 32'(RegWrite), 32'(0));

    // Back-pressure with eight held pair requests
    max_run = 0; k = 0; first_block = -1;
    @(posedge clock); #1;
    req_valid = 1'b1; req_pair = 1'b1; req_addr = '0; req_data = 16'h0000;
    for (int cyc = 0; cyc < 100 && k < 8; cyc++) begin
      @(negedge clock);
      acc = req_ready;
      if (!acc && first_block < 0) first_block = k;
      @(posedge clock); #1;
      if (acc) begin
        k++;
        if (k < 8) begin
          req_addr = AW'(2 * k);
          req_data = 16'(32'h1100 * k + k);
        end else begin
          req_valid = 1'b0;
        end
      end
    end
    req_valid = 1'b0;
    chk("bp_accepted", 32'(k), 32'(8));
    chk("bp_ready_drop_after", 32'(first_block), 32'(6));
    wait_idle("bp_drain");
    chk("bp_continuous_run", 32'(max_run), 32'(16));
    chk("bp_all_issued", 32'(exp_q.size()), 32'(0));

    // Hazard against a pending pair
    hz_addr = 5'd31;
    issue_req(5'd30, 1'b1, 16'h7788);
    @(negedge clock);
    chk("hz_31_pending", 32'(hz_match), 32'(1));
    #1 hz_addr = 5'd30;
    #1 chk("hz_30_pending", 32'(hz_match), 32'(1));
    hz_addr = 5'd29;
    #1 chk("hz_29_pending", 32'(hz_match), 32'(0));
    hz_addr = 5'd31;
    wait_idle("hz_drain");
    chk("hz_31_after", 32'(hz_match), 32'(0));

    // Reset while the high byte of a pair is pending
    issue_req(5'd25, 1'b1, 16'h1234);
    @(negedge clock);
    @(negedge clock);
    chk("rm_lo_rw", 32'(RegWrite), 32'(1));
    chk("rm_lo_wa", 32'(WA), 32'(24));
    #1 clr_n = 1'b0;
    exp_q.delete();
    pend_q.delete();
    #1 chk("rm_async_rw", 32'(RegWrite), 32'(0));
    @(posedge clock); @(posedge clock); #1 clr_n = 1'b1;
    @(negedge clock);
    chk("rm_busy", 32'(busy), 32'(0));
    chk("rm_ready", 32'(req_ready), 32'(1));
    chk("rm_rw", 32'(RegWrite), 32'(0));
    repeat (3) @(negedge clock);
    chk("rm_reg25", 32'(rf_dut[25]), 32'(8'hBE));
    chk("rm_reg24", 32'(rf_dut[24]), 32'(8'h34));

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      @(posedge clock); #1;
      req_valid = ($urandom_range(0, 99) < 55);
      req_addr  = AW'($urandom);
      req_pair  = 1'($urandom);
      req_data  = 16'($urandom);
      hz_addr   = AW'($urandom);
    end
    @(posedge clock); #1 req_valid = 1'b0;
    wait_idle("rand_drain");
    chk("rand_all_issued", 32'(exp_q.size()), 32'(0));
    for (int r = 0; r < 32; r++)
      chk($sformatf("rf_r%0d", r), 32'(rf_dut[r]), 32'(rf_ref[r]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
